czonotope_stream_tx: RTL and testbench

CZONOTOPE_STREAM_TX -- requirements
Module: czonotope_stream_tx

---
 rtl/czonotope_pkg.sv | 32 +++
 rtl/czonotope_if.sv | 18 +
 rtl/czonotope_idx_counter.sv | 38 +++
 rtl/czonotope_stream_tx.sv | 200 ++++++++++++++++++++
 tb/tb_czonotope_stream_tx.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/czonotope_pkg.sv
// Shared definitions for the constrained-zonotope stream transmitter:
// FSM encoding, tuser field tags and header field layout.
package czonotope_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_C,
    ST_G,
    ST_A,
    ST_B,
    ST_DONE
  } state_t;

  localparam logic [2:0] TAG_HDR = 3'd0;
  localparam logic [2:0] TAG_C   = 3'd1;
  localparam logic [2:0] TAG_G   = 3'd2;
  localparam logic [2:0] TAG_A   = 3'd3;
  localparam logic [2:0] TAG_B   = 3'd4;
  localparam logic [2:0] TAG_ERR = 3'd7;

  localparam int HDR_FIELD_W = 8;
  localparam int HDR_N_LSB   = 0;
  localparam int HDR_NG_LSB  = 8;
  localparam int HDR_NC_LSB  = 16;

  // Index width for a counter spanning 0..max_val-1; never narrower than one bit.
  function automatic int idx_w(input int max_val);
    return (max_val > 1) ? $clog2(max_val) : 1;
  endfunction

endpackage

// File: rtl/czonotope_if.sv
// Read-only view of a constrained zonotope: dimensions plus the c, G, A and b
// element arrays, addressed combinationally by the consumer.
interface czonotope_if #(
  parameter int NMAX       = 3,
  parameter int NGMAX      = 15,
  parameter int NCMAX      = 12,
  parameter int DATA_WIDTH = 32
);
  logic [7:0]            n;
  logic [7:0]            ng;
  logic [7:0]            nc;
  logic [DATA_WIDTH-1:0] c [NMAX];
  logic [DATA_WIDTH-1:0] G [NMAX][NGMAX];
  logic [DATA_WIDTH-1:0] A [NCMAX][NGMAX];
  logic [DATA_WIDTH-1:0] b [NCMAX];

  modport rd (input n, ng, nc, c, G, A, b);
endinterface

// File: rtl/czonotope_idx_counter.sv
// Row-major 2-D index counter: column steps first, both wrap to zero at the
// supplied last indices, and last flags the final element of the section.
module czonotope_idx_counter #(
  parameter int ROW_W = 4,
  parameter int COL_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             advance,
  input  logic [ROW_W-1:0] row_last,
  input  logic [COL_W-1:0] col_last,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic             last
);
  logic row_end;
  logic col_end;

  assign row_end = (row == row_last);
  assign col_end = (col == col_last);
  assign last    = row_end & col_end;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      row <= '0;
      col <= '0;
    end else if (advance) begin
      if (col_end) begin
        col <= '0;
        row <= row_end ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

endmodule

// File: rtl/czonotope_stream_tx.sv
// Serialises a constrained zonotope as HDR, c, G, A, b beats over a
// valid/ready stream; oversized dimensions yield a single tagged error beat.
module czonotope_stream_tx
  import czonotope_pkg::*;
#(
  parameter int NMAX       = 3,
  parameter int NGMAX      = 15,
  parameter int NCMAX      = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  start_i,
  czonotope_if.rd               Z,
  output logic [DATA_WIDTH-1:0] tdata_o,
  output logic                  tvalid_o,
  input  logic                  tready_i,
  output logic                  tlast_o,
  output logic [2:0]            tuser_o,
  output logic                  busy_o,
  output logic                  done_o
);

  localparam int ROW_W = idx_w((NMAX > NCMAX) ? NMAX : NCMAX);
  localparam int COL_W = idx_w(NGMAX);

  localparam logic [7:0] NMAX_B  = 8'(NMAX);
  localparam logic [7:0] NGMAX_B = 8'(NGMAX);
  localparam logic [7:0] NCMAX_B = 8'(NCMAX);

  state_t                state;
  state_t                state_nx;
  state_t                section_after;
  logic [7:0]            n_q;
  logic [7:0]            ng_q;
  logic [7:0]            nc_q;
  logic                  dim_err;
  logic                  has_c;
  logic                  has_g;
  logic                  has_a;
  logic                  has_b;
  logic                  start_ok;
  logic                  accept;
  logic                  advance;
  logic [ROW_W-1:0]      row;
  logic [COL_W-1:0]      col;
  logic [ROW_W-1:0]      row_last;
  logic [COL_W-1:0]      col_last;
  logic [ROW_W-1:0]      n_last;
  logic [ROW_W-1:0]      nc_last;
  logic [COL_W-1:0]      ng_last;
  logic                  idx_last;
  logic [DATA_WIDTH-1:0] hdr_word;

  // First non-empty section following s; DONE when nothing remains.
  function automatic state_t next_section(input state_t s, input logic hc,
                                          input logic hg, input logic ha,
                                          input logic hb);
    state_t nx;
    nx = ST_DONE;
    case (s)
      ST_HDR:  nx = hc ? ST_C : hg ? ST_G : ha ? ST_A : hb ? ST_B : ST_DONE;
      ST_C:    nx = hg ? ST_G : ha ? ST_A : hb ? ST_B : ST_DONE;
      ST_G:    nx = ha ? ST_A : hb ? ST_B : ST_DONE;
      ST_A:    nx = hb ? ST_B : ST_DONE;
      default: nx = ST_DONE;
    endcase
    return nx;
  endfunction

  assign start_ok = start_i && (state == ST_IDLE);
  assign accept   = tvalid_o && tready_i;
  assign advance  = accept && (state inside {ST_C, ST_G, ST_A, ST_B});

  assign dim_err = (n_q > NMAX_B) || (ng_q > NGMAX_B) || (nc_q > NCMAX_B);
  assign has_c   = (n_q != 8'd0);
  assign has_g   = (n_q != 8'd0) && (ng_q != 8'd0);
  assign has_a   = (nc_q != 8'd0) && (ng_q != 8'd0);
  assign has_b   = (nc_q != 8'd0);

  assign section_after = next_section(state, has_c, has_g, has_a, has_b);

  // Last-index values only matter inside a non-empty section, so the
  // wrap-around of a zero dimension is never observed.
  assign n_last  = ROW_W'(n_q - 8'd1);
  assign nc_last = ROW_W'(nc_q - 8'd1);
  assign ng_last = COL_W'(ng_q - 8'd1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
      n_q   <= '0;
      ng_q  <= '0;
      nc_q  <= '0;
    end else begin
      state <= state_nx;
      if (start_ok) begin
        n_q  <= Z.n;
        ng_q <= Z.ng;
        nc_q <= Z.nc;
      end
    end
  end

  czonotope_idx_counter #(
    .ROW_W (ROW_W),
    .COL_W (COL_W)
  ) u_idx (
    .clk      (clk_i),
    .rst      (rst_i),
    .clear    (start_ok),
    .advance  (advance),
    .row_last (row_last),
    .col_last (col_last),
    .row      (row),
    .col      (col),
    .last     (idx_last)
  );

  always_comb begin
    hdr_word = '0;
    hdr_word[HDR_N_LSB  +: HDR_FIELD_W] = n_q;
    hdr_word[HDR_NG_LSB +: HDR_FIELD_W] = ng_q;
    hdr_word[HDR_NC_LSB +: HDR_FIELD_W] = nc_q;
  end

  always_comb begin
    state_nx = state;
    tvalid_o = 1'b0;
    tlast_o  = 1'b0;
    tuser_o  = TAG_HDR;
    tdata_o  = '0;
    busy_o   = 1'b0;
    done_o   = 1'b0;
    row_last = '0;
    col_last = '0;
    case (state)
      ST_IDLE: begin
        if (start_i) state_nx = ST_HDR;
      end
      ST_HDR: begin
        busy_o   = 1'b1;
        tvalid_o = 1'b1;
        tdata_o  = hdr_word;
        if (dim_err) begin
          tuser_o = TAG_ERR;
          tlast_o = 1'b1;
          if (tready_i) state_nx = ST_DONE;
        end else begin
          tlast_o = (section_after == ST_DONE);
          if (tready_i) state_nx = section_after;
        end
      end
      ST_C: begin
        busy_o   = 1'b1;
        tvalid_o = 1'b1;
        tuser_o  = TAG_C;
        row_last = n_last;
        tdata_o  = Z.c[row];
        tlast_o  = idx_last && (section_after == ST_DONE);
        if (accept && idx_last) state_nx = section_after;
      end
      ST_G: begin
        busy_o   = 1'b1;
        tvalid_o = 1'b1;
        tuser_o  = TAG_G;
        row_last = n_last;
        col_last = ng_last;
        tdata_o  = Z.G[row][col];
        tlast_o  = idx_last && (section_after == ST_DONE);
        if (accept && idx_last) state_nx = section_after;
      end
      ST_A: begin
        busy_o   = 1'b1;
        tvalid_o = 1'b1;
        tuser_o  = TAG_A;
        row_last = nc_last;
        col_last = ng_last;
        tdata_o  = Z.A[row][col];
        tlast_o  = idx_last && (section_after == ST_DONE);
        if (accept && idx_last) state_nx = section_after;
      end
      ST_B: begin
        busy_o   = 1'b1;
        tvalid_o = 1'b1;
        tuser_o  = TAG_B;
        row_last = nc_last;
        tdata_o  = Z.b[row];
        tlast_o  = idx_last;
        if (accept && idx_last) state_nx = ST_DONE;
      end
      ST_DONE: begin
        done_o   = 1'b1;
        state_nx = ST_IDLE;
      end
      default: state_nx = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_czonotope_stream_tx.sv
// Scoreboard bench for czonotope_stream_tx: a set-level model queues the
// expected beats, a negedge monitor compares every presented beat.
module tb_czonotope_stream_tx;

  localparam int NMAX  = 3;
  localparam int NGMAX = 15;
  localparam int NCMAX = 12;
  localparam int DW    = 32;

  typedef struct packed {
    logic [DW-1:0] data;
    logic [2:0]    user;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          tready = 1'b0;
  logic [DW-1:0] tdata;
  logic          tvalid;
  logic          tlast;
  logic [2:0]    tuser;
  logic          busy;
  logic          done;

  czonotope_if #(.NMAX(NMAX), .NGMAX(NGMAX), .NCMAX(NCMAX), .DATA_WIDTH(DW)) zif ();

  czonotope_stream_tx #(
    .NMAX(NMAX), .NGMAX(NGMAX), .NCMAX(NCMAX), .DATA_WIDTH(DW)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .start_i  (start),
    .Z        (zif),
    .tdata_o  (tdata),
    .tvalid_o (tvalid),
    .tready_i (tready),
    .tlast_o  (tlast),
    .tuser_o  (tuser),
    .busy_o   (busy),
    .done_o   (done)
  );

  initial forever #5 clk = ~clk;

  beat_t exp_q[$];
  beat_t mon_e;
  int    vectors = 0;
  int    miscompares = 0;
  int    acc_cnt = 0;
  int    acc_base = 0;
  int    done_cnt = 0;
  int    ready_mode = 0;
  int    cyc = 0;
  bit    mon_en = 1'b0;
  bit    expect_done = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a set is its header, then c, G, A, b in row-major order.
  function automatic int push_expected(input int n, input int ng, input int nc);
    beat_t q[$];
    beat_t e;
    bit    err;
    err = (n > NMAX) || (ng > NGMAX) || (nc > NCMAX);
    e.data = '0;
    e.data[7:0]   = 8'(n);
    e.data[15:8]  = 8'(ng);
    e.data[23:16] = 8'(nc);
    e.user = err ? 3'd7 : 3'd0;
    e.last = 1'b0;
    q.push_back(e);
    if (!err) begin
      for (int i = 0; i < n; i++) begin
        e.data = zif.c[i]; e.user = 3'd1; q.push_back(e);
      end
      for (int i = 0; i < n; i++)
        for (int j = 0; j < ng; j++) begin
          e.data = zif.G[i][j]; e.user = 3'd2; q.push_back(e);
        end
      for (int i = 0; i < nc; i++)
        for (int j = 0; j < ng; j++) begin
          e.data = zif.A[i][j]; e.user = 3'd3; q.push_back(e);
        end
      for (int i = 0; i < nc; i++) begin
        e.data = zif.b[i]; e.user = 3'd4; q.push_back(e);
      end
    end
    q[q.size()-1].last = 1'b1;
    foreach (q[k]) exp_q.push_back(q[k]);
    return q.size();
  endfunction

  task automatic load_set(input int n, input int ng, input int nc, input bit fixed_c);
    for (int i = 0; i < NMAX; i++) begin
      zif.c[i] = $urandom;
      for (int j = 0; j < NGMAX; j++) zif.G[i][j] = $urandom;
    end
    for (int i = 0; i < NCMAX; i++) begin
      zif.b[i] = $urandom;
      for (int j = 0; j < NGMAX; j++) zif.A[i][j] = $urandom;
    end
    if (fixed_c) begin
      zif.c[0] = 32'h3F80_0000;
      zif.c[1] = 32'h4000_0000;
    end
    zif.n  = 8'(n);
    zif.ng = 8'(ng);
    zif.nc = 8'(nc);
  endtask

  task automatic pulse_start();
    @(posedge clk); #2 start = 1'b1;
    @(posedge clk); #2 start = 1'b0;
  endtask

  task automatic run_set(input int n, input int ng, input int nc, input int mode,
                         input bit fixed_c, input bit extra_start);
    int total;
    int base_done;
    ready_mode = mode;
    load_set(n, ng, nc, fixed_c);
    total     = push_expected(n, ng, nc);
    acc_base  = acc_cnt;
    base_done = done_cnt;
    pulse_start();
    @(negedge clk);
    check("latency_tvalid", tvalid, 1);
    if (extra_start) begin
      @(negedge clk);
      check("busy_before_restart", busy, 1);
      pulse_start();
    end
    for (int k = 0; k < 3000 && done_cnt == base_done; k++) @(posedge clk);
    check("done_seen", done_cnt - base_done, 1);
    check("beat_count", acc_cnt - acc_base, total);
    check("queue_drained", exp_q.size(), 0);
    @(negedge clk);
    check("busy_after_done", busy, 0);
    exp_q.delete();
  endtask

  // Downstream ready patterns.
  initial forever begin
    @(posedge clk); #1;
    cyc++;
    case (ready_mode)
      0:       tready = 1'b1;
      1:       tready = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      2:       tready = ($urandom_range(0, 2) != 0);
      default: tready = ((acc_cnt - acc_base) < 4);
    endcase
  end

  // Monitor: every presented beat must match the head of the queue.
  initial forever begin
    @(negedge clk);
    if (mon_en) begin
      check("done_o", done, expect_done);
      if (done) done_cnt++;
      expect_done = 1'b0;
      if (tvalid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", tvalid, 0);
        end else begin
          mon_e = exp_q[0];
          check("tdata", tdata, mon_e.data);
          check("tuser", tuser, mon_e.user);
          check("tlast", tlast, mon_e.last);
          if (tready) begin
            void'(exp_q.pop_front());
            acc_cnt++;
            if (mon_e.last) expect_done = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    load_set(0, 0, 0, 1'b0);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tvalid", tvalid, 0);
    check("rst_tlast", tlast, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_tdata", tdata, 0);
    check("rst_tuser", tuser, 0);
    @(posedge clk); #2 rst = 1'b0;
    mon_en = 1'b1;

    run_set(2, 2, 1, 0, 1'b1, 1'b0);
    run_set(2, 2, 1, 1, 1'b1, 1'b0);
    run_set(3, 1, 0, 2, 1'b0, 1'b0);
    run_set(3, 16, 0, 0, 1'b0, 1'b0);

    // Reset while beat 4 is stalled.
    ready_mode = 3;
    load_set(2, 2, 1, 1'b1);
    void'(push_expected(2, 2, 1));
    acc_base = acc_cnt;
    pulse_start();
    base = 0;
    while (acc_cnt - acc_base < 4 && base < 200) begin
      @(posedge clk);
      base++;
    end
    check("reach_beat4", acc_cnt - acc_base, 4);
    @(negedge clk);
    check("beat4_stalled_valid", tvalid, 1);
    @(posedge clk); #2 rst = 1'b1;
    @(posedge clk); #2 rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("midrst_tvalid", tvalid, 0);
    check("midrst_busy", busy, 0);
    ready_mode = 0;
    repeat (3) @(negedge clk);
    check("midrst_quiet", tvalid, 0);

    run_set(2, 2, 1, 0, 1'b0, 1'b0);
    run_set(2, 2, 1, 1, 1'b0, 1'b1);
    run_set(0, 0, 0, 0, 1'b0, 1'b0);
    run_set(0, 4, 3, 2, 1'b0, 1'b0);
    run_set(2, 0, 3, 2, 1'b0, 1'b0);
    run_set(4, 1, 1, 2, 1'b0, 1'b0);
    run_set(1, 1, 13, 0, 1'b0, 1'b0);
    run_set(3, 15, 12, 2, 1'b0, 1'b0);
    for (int t = 0; t < 8; t++)
      run_set($urandom_range(0, NMAX), $urandom_range(0, NGMAX),
              $urandom_range(0, NCMAX), $urandom_range(0, 2), 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
